// File: rtl/painterengine_gpu_dma_reader_if.sv
// AXI4 read-address/read-data channels plus the FIFO push port of the GPU DMA reader.
// master = the reader, slave = interconnect + FIFO side.
interface painterengine_gpu_dma_reader_if;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        fifo_full;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output fifo_wr_en, fifo_wr_data,
        input  fifo_full
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  fifo_wr_en, fifo_wr_data,
        output fifo_full
    );
endinterface

// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master for the GPU copy/convert pipeline: one transfer per reset release, 4KB-safe bursts.
// Optional R/AR watchdog enabled by defining GPU_DMA_READER_TIMEOUT_EN.
module painterengine_gpu_dma_reader #(
    parameter int unsigned BURST_MAX      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic [31:0] i_wire_address,
    input  logic [31:0] i_wire_length,
    output logic        o_wire_done,
    output logic        o_wire_error,
    painterengine_gpu_dma_reader_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t      state;
    logic [31:0] cur_addr;
    logic [31:0] remaining;
    logic [8:0]  beats;
    logic [8:0]  beat_cnt;
    logic        done;
    logic        error;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;

    logic        ar_hs;
    logic        rready;
    logic        r_hs;
    logic        beat_ok;
    logic        last_beat;
    logic        wd_expire;
    logic [31:0] next_addr;
    logic [31:0] next_rem;
    logic [8:0]  idle_beats;
    logic [8:0]  cont_beats;

    // Burst size is capped by what is left, by BURST_MAX and by the distance to the next 4KB page.
    function automatic logic [8:0] burst_beats(input logic [31:0] rem, input logic [11:0] page_off);
        logic [12:0] to_page;
        logic [8:0]  b;
        to_page = 13'((13'd4096 - {1'b0, page_off}) >> 2);
        b = (rem > BURST_MAX) ? 9'(BURST_MAX) : rem[8:0];
        if ({4'd0, b} > to_page)
            b = to_page[8:0];
        return b;
    endfunction

    assign ar_hs      = arvalid && bus.m_axi_arready;
    assign rready     = (state == ST_DATA) && !bus.fifo_full;
    assign r_hs       = bus.m_axi_rvalid && rready;
    assign beat_ok    = (bus.m_axi_rresp == 2'b00);
    assign last_beat  = (beat_cnt == beats - 9'd1);
    assign next_addr  = cur_addr + {21'd0, beats, 2'b00};
    assign next_rem   = remaining - {23'd0, beats};
    assign idle_beats = burst_beats(i_wire_length, i_wire_address[11:0]);
    assign cont_beats = burst_beats(next_rem, next_addr[11:0]);

    assign bus.m_axi_araddr  = araddr;
    assign bus.m_axi_arlen   = arlen;
    assign bus.m_axi_arsize  = 3'b010;
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = arvalid;
    assign bus.m_axi_rready  = rready;
    // Zero-latency push: the accepted beat goes straight into the FIFO.
    assign bus.fifo_wr_en    = r_hs && beat_ok;
    assign bus.fifo_wr_data  = bus.m_axi_rdata;
    assign o_wire_done       = done;
    assign o_wire_error      = error;

`ifdef GPU_DMA_READER_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        wd_idle;

    // FIFO back-pressure is our own stall, not a stuck slave, so it does not age the watchdog.
    assign wd_idle   = ((state == ST_ADDR) || (state == ST_DATA)) && !ar_hs && !r_hs &&
                       !((state == ST_DATA) && bus.fifo_full);
    assign wd_expire = wd_idle && (wd_cnt == TIMEOUT_CYCLES - 1);

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            wd_cnt <= 32'd0;
        end else if (ar_hs || r_hs || !((state == ST_ADDR) || (state == ST_DATA))) begin
            wd_cnt <= 32'd0;
        end else if (wd_idle) begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end
`else
    // Without the watchdog the timeout parameter has no effect.
    assign wd_expire = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state     <= ST_IDLE;
            cur_addr  <= 32'd0;
            remaining <= 32'd0;
            beats     <= 9'd0;
            beat_cnt  <= 9'd0;
            done      <= 1'b0;
            error     <= 1'b0;
            arvalid   <= 1'b0;
            araddr    <= 32'd0;
            arlen     <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_wire_address[1:0] != 2'b00) begin
                        error <= 1'b1;
                        state <= ST_ERROR;
                    end else if (i_wire_length == 32'd0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cur_addr  <= i_wire_address;
                        remaining <= i_wire_length;
                        beats     <= idle_beats;
                        araddr    <= i_wire_address;
                        arlen     <= 8'(idle_beats - 9'd1);
                        arvalid   <= 1'b1;
                        state     <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (ar_hs) begin
                        arvalid  <= 1'b0;
                        beat_cnt <= 9'd0;
                        state    <= ST_DATA;
                    end else if (wd_expire) begin
                        arvalid <= 1'b0;
                        error   <= 1'b1;
                        state   <= ST_ERROR;
                    end
                end

                ST_DATA: begin
                    if (r_hs) begin
                        if (!beat_ok || (bus.m_axi_rlast != last_beat)) begin
                            error <= 1'b1;
                            state <= ST_ERROR;
                        end else if (last_beat) begin
                            cur_addr  <= next_addr;
                            remaining <= next_rem;
                            if (next_rem == 32'd0) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                // Next AR goes out on the cycle right after the final beat.
                                beats   <= cont_beats;
                                araddr  <= next_addr;
                                arlen   <= 8'(cont_beats - 9'd1);
                                arvalid <= 1'b1;
                                state   <= ST_ADDR;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                        end
                    end else if (wd_expire) begin
                        error <= 1'b1;
                        state <= ST_ERROR;
                    end
                end

                ST_DONE: begin
                    done <= 1'b1;
                end

                ST_ERROR: begin
                    error <= 1'b1;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
